ahb_lite_bus_master: RTL and testbench
======================================

Name: ahb_lite_bus_master

Overview:
- Single-master AHB-Lite bus interface for the multicycle core. It sits directly downstream of the core control FSM.
- Consumes the FSM's fetch-enable and memory-enable pulses and performs one SINGLE AHB transfer for each.
- Returns the fetched instruction or the load data to the datapath, with done/err pulses.
- Stores are issued with byte-lane-replicated write data.

Parameters:
- ADDR_W, 32, AHB address width and width of pc/mem_addr.
- DATA_W, 32, AHB data width. Only 32 is supported.

Ports:
- clk  in  1  core clock; also the AHB HCLK.
- reset  in  1  synchronous, active-high reset.
- if_en  in  1  one-cycle fetch request pulse.
- pc  in  ADDR_W  fetch address, sampled with if_en.
- mem_en  in  1  one-cycle data access request pulse.
- mem_we  in  1  1=store, 0=load; sampled with mem_en.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  32  store data, right-justified.
- instr  out  32  last fetched instruction (registered).
- rdata  out  32  last load data: right-justified, zero-extended.
- busy  out  1  high while a transfer is active or a request is pending.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on HRESP error or misalignment; coincides with done.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  AHB transfer type.
- HWRITE  out  1  AHB write flag.
- HSIZE  out  3  AHB transfer size.
- HBURST  out  3  constant SINGLE (000).
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response: 0 OKAY, 1 ERROR.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE; pending flags are cleared.
  - All outputs go to 0, including HTRANS=IDLE and instr=rdata=0.
  - Reset mid-transfer abandons the transfer immediately; no done pulse is generated.
- All AHB outputs are driven from registers.
- States:
  - IDLE: no transfer in progress.
  - ADDR: address phase. HTRANS=NONSEQ; HADDR/HWRITE/HSIZE valid.
  - DATA: data phase. HTRANS=IDLE, HWDATA valid, waiting for HREADY.
- Request capture:
  - if_en or mem_en sets the corresponding pending flag and latches its address/controls.
  - A request arriving while the same kind is already pending is ignored; flag it with a bench assertion.
- Dispatch from IDLE:
  - If fetch is pending, go to ADDR for the fetch; otherwise if mem is pending, go to ADDR for the mem access.
  - Fetch takes priority when if_en and mem_en coincide.
- ADDR to DATA:
  - Advance when HREADY=1; otherwise hold ADDR with all address signals stable.
- DATA completion, at the edge where HREADY=1:
  - Capture instr (fetch) or rdata (load).
  - Clear the pending flag.
  - Pulse done the next cycle.
  - If HRESP=1 on that edge, pulse err alongside done, and leave instr/rdata unchanged.
  - Return to IDLE.
- Latency, zero wait states:
  - Request at cycle T, address phase T+1, data phase T+2.
  - done and data valid at T+3, in IDLE.
  - A pending second request starts its address phase at T+4.
- Wait states: each cycle with HREADY=0 in ADDR or DATA adds one cycle of latency.
- Misaligned mem access (half with addr[0]=1; word with addr[1:0]!=0):
  - No bus transfer.
  - done and err pulse one cycle after the access is dispatched from IDLE.
- HSIZE mapping: byte=000, half=001, word=010. HADDR carries the full byte address.
- Store lanes:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata as-is
- Load extraction: shift HRDATA right by 8*addr[1:0], mask to the access size, zero-extend. Sign extension is done downstream in writeback.
- busy = any pending flag OR state≠IDLE.

Decomposition:
- Package ahb_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10.
  - HSIZE_BYTE/HALF/WORD, HBURST_SINGLE.
  - HRESP_OKAY/ERROR.
  - mem_size_t enum, bm_state_t enum.
- Sub-module ahb_lane_align (combinational): store lane replication, load lane extraction, misalignment detect.

Test Plan:
- Fetch, zero-wait: if_en=1, pc=0x100, slave returns 0x00A00093 → HTRANS=NONSEQ at T+1, HADDR=0x100; done at T+3 with instr=0x00A00093, err=0.
- Load byte, 2 wait states: mem_addr=0x203, size=byte, HRDATA=0x80FF_1234 → HSIZE=000; done at T+5; rdata=0x00000080.
- Store half, zero-wait: mem_addr=0x302, wdata=0xDEADBEEF → HWRITE=1, HSIZE=001, HWDATA=0xBEEFBEEF in the data phase; done at T+3; rdata unchanged.
- Error response: fetch with slave returning HREADY=0/HRESP=1 then HREADY=1/HRESP=1 → done and err pulse together; instr keeps its previous value.
- Simultaneous requests: if_en and mem_en (load, 0x400) in the same cycle → fetch completes first (done T+3), load address phase at T+4, second done at T+6; busy high throughout.
- Misaligned access and reset: word load at 0x401 → no NONSEQ, done+err one cycle after dispatch. Reset asserted during a DATA wait → next cycle HTRANS=IDLE, busy=0, no done.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the enums used by the bus master.
//   HTRANS/HSIZE/HBURST/HRESP encodings, the core-side access size enum and
//   the bus master FSM state enum.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Core-side access size; the 2'b11 code behaves exactly like a word.
  typedef enum logic [1:0] {
    MEM_BYTE     = 2'b00,
    MEM_HALF     = 2'b01,
    MEM_WORD     = 2'b10,
    MEM_WORD_ALT = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } bm_state_t;

endpackage

// File: rtl/ahb_lane_align.sv
// ahb_lane_align: combinational byte-lane handling for a 32-bit AHB port.
//   size       in   access size of the data request
//   addr_lo    in   low two bits of the byte address
//   wdata      in   right-justified store data
//   hrdata     in   raw AHB read data
//   hsize      out  AHB HSIZE encoding for the access
//   hwdata     out  store data replicated across all byte lanes
//   rdata      out  load data shifted down and zero-extended
//   misaligned out  half on an odd address, or word not on a 4-byte boundary
module ahb_lane_align
  import ahb_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    // Byte lane addr_lo lands in bits [7:0] after this shift.
    shifted = hrdata >> {addr_lo, 3'b000};
    case (size)
      MEM_BYTE: begin
        hsize      = HSIZE_BYTE;
        hwdata     = {4{wdata[7:0]}};
        rdata      = {24'h0, shifted[7:0]};
        misaligned = 1'b0;
      end
      MEM_HALF: begin
        hsize      = HSIZE_HALF;
        hwdata     = {2{wdata[15:0]}};
        rdata      = {16'h0, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        hsize      = HSIZE_WORD;
        hwdata     = wdata;
        rdata      = shifted;
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_bus_master.sv
// ahb_lite_bus_master: single-master AHB-Lite interface for the multicycle
// core. Each fetch or data request pulse becomes one SINGLE transfer.
//   clk, reset         core clock (HCLK) and synchronous active-high reset
//   if_en, pc          fetch request pulse and fetch address
//   mem_en, mem_we,
//   mem_size, mem_addr,
//   mem_wdata          data request pulse, direction, size, address, data
//   instr, rdata       last fetched instruction / last zero-extended load
//   busy               a request is pending or a transfer is in flight
//   done, err          one-cycle completion pulse, error pulse alongside it
//   HADDR..HWDATA      registered AHB master outputs
//   HRDATA/HREADY/HRESP AHB slave response
//   dbg_state          current FSM state, for observation only
//
// Handshake: if_en/mem_en are single-cycle pulses, each accepted only when no
// request of the same kind is pending; done (with err) closes the oldest
// accepted request. AHB side: a transfer advances on every edge with HREADY=1.
module ahb_lite_bus_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output bm_state_t         dbg_state
);

  bm_state_t         state_q, state_d;
  logic              pend_if_q, pend_if_d;
  logic              pend_mem_q, pend_mem_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic              mem_we_q, mem_we_d;
  mem_size_t         mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cur_fetch_q, cur_fetch_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;

  // Pending flags including requests arriving this cycle, before the FSM
  // clears anything.
  logic              if_req, mem_req;

  logic [2:0]        al_hsize;
  logic [31:0]       al_hwdata;
  logic [31:0]       al_rdata;
  logic              al_misaligned;

  // The aligner looks at the latched data request; while a data transfer is
  // in flight those fields cannot change, so the same view serves dispatch
  // and load extraction.
  ahb_lane_align u_align (
    .size       (mem_size_d),
    .addr_lo    (mem_addr_d[1:0]),
    .wdata      (mem_wdata_d),
    .hrdata     (HRDATA),
    .hsize      (al_hsize),
    .hwdata     (al_hwdata),
    .rdata      (al_rdata),
    .misaligned (al_misaligned)
  );

  // Request capture: a request of a kind already pending is dropped.
  always_comb begin
    if_req      = pend_if_q;
    if_addr_d   = if_addr_q;
    mem_req     = pend_mem_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (if_en && !pend_if_q) begin
      if_req    = 1'b1;
      if_addr_d = pc;
    end
    if (mem_en && !pend_mem_q) begin
      mem_req     = 1'b1;
      mem_we_d    = mem_we;
      mem_size_d  = mem_size_t'(mem_size);
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_if_d   = if_req;
    pend_mem_d  = mem_req;
    cur_fetch_d = cur_fetch_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (if_req) begin
          state_d     = ST_ADDR;
          cur_fetch_d = 1'b1;
          haddr_d     = if_addr_d;
          htrans_d    = HTRANS_NONSEQ;
          hwrite_d    = 1'b0;
          hsize_d     = HSIZE_WORD;
        end else if (mem_req) begin
          if (al_misaligned) begin
            // Never reaches the bus: finish with an error straight away.
            pend_mem_d = 1'b0;
            done_d     = 1'b1;
            err_d      = 1'b1;
          end else begin
            state_d     = ST_ADDR;
            cur_fetch_d = 1'b0;
            haddr_d     = mem_addr_d;
            htrans_d    = HTRANS_NONSEQ;
            hwrite_d    = mem_we_d;
            hsize_d     = al_hsize;
            hwdata_d    = al_hwdata;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = (HRESP == HRESP_ERROR);
          if (cur_fetch_q) begin
            pend_if_d = 1'b0;
            if (HRESP == HRESP_OKAY) instr_d = HRDATA;
          end else begin
            pend_mem_d = 1'b0;
            if (HRESP == HRESP_OKAY && !mem_we_q) rdata_d = al_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_if_q   <= 1'b0;
      pend_mem_q  <= 1'b0;
      if_addr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= MEM_BYTE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cur_fetch_q <= 1'b0;
      instr_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_if_q   <= pend_if_d;
      pend_mem_q  <= pend_mem_d;
      if_addr_q   <= if_addr_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cur_fetch_q <= cur_fetch_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
    end
  end

  assign instr     = instr_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = pend_if_q || pend_mem_q || (state_q != ST_IDLE);
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = HBURST_SINGLE;
  assign HWDATA    = hwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_lite_bus_master.sv
// tb_ahb_lite_bus_master: table vectors, hand-written multi-cycle sequences
// and randomized transfers against a behavioural model of the bus master.
module tb_ahb_lite_bus_master;
  import ahb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_en = 1'b0;
  logic [31:0] pc = '0;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] instr, rdata;
  logic        busy, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  bm_state_t   dbg_state;

  always #5 clk = ~clk;

  ahb_lite_bus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .if_en(if_en), .pc(pc),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr(instr), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .dbg_state(dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- slave model ----------------
  logic        data_active = 1'b0;
  logic        in_data = 1'b0;
  int          aw_left = 0;
  int          dw_left = 0;
  int          plan_dw = 0;
  logic        cur_err = 1'b0;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_data = '0;
  logic [31:0] data_addr = '0;
  int          cyc = 0;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A3C3C;
  endfunction

  // Called at each falling edge: decides this cycle's HREADY/HRESP/HRDATA.
  task automatic slave_update();
    in_data = data_active;
    HRDATA  = 32'hDEAD0000 ^ cyc;
    if (data_active) begin
      HRESP = cur_err;
      if (dw_left > 0) begin
        HREADY = 1'b0;
        dw_left--;
      end else begin
        HREADY      = 1'b1;
        HRDATA      = use_ovr ? ovr_data : slave_word(data_addr);
        data_active = 1'b0;
      end
    end else if (HTRANS == HTRANS_NONSEQ) begin
      HRESP = 1'b0;
      if (aw_left > 0) begin
        HREADY = 1'b0;
        aw_left--;
      end else begin
        HREADY      = 1'b1;
        data_active = 1'b1;
        data_addr   = HADDR;
        dw_left     = plan_dw;
      end
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    slave_update();
  endtask

  // ---------------- duplicate-request assertion ----------------
  logic tb_if_pend = 1'b0;
  logic tb_mem_pend = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(if_en && tb_if_pend)) else $error("fetch request while a fetch is pending");
      assert (!(mem_en && tb_mem_pend)) else $error("data request while a data access is pending");
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          kind;   // 0 fetch, 1 data
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    logic        rerr;
    logic        ovr;
    logic [31:0] hrd;
  } op_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] val;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  logic [31:0] m_instr = '0;
  logic [31:0] m_rdata = '0;

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [2:0] m_hsize(input logic [1:0] s);
    return (size_bytes(s) == 1) ? 3'd0 : (size_bytes(s) == 2) ? 3'd1 : 3'd2;
  endfunction

  function automatic bit m_mis(input logic [1:0] s, input logic [31:0] a);
    return (a % size_bytes(s)) != 0;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [1:0] s, input logic [31:0] w);
    if (size_bytes(s) == 1) return (w & 32'hFF) * 32'h01010101;
    if (size_bytes(s) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_extract(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    mask = (size_bytes(s) == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size_bytes(s))) - 32'd1);
    return (d >> (8 * (a % 4))) & mask;
  endfunction

  // ---------------- driver: one request, observed to completion ----------------
  task automatic run_op(input string tag, input op_t op, input exp_t ex);
    int          done_c;
    logic        err_s, busy_done, seen_addr, busy_bad, a_write;
    logic [31:0] a_addr, wd_seen;
    logic [2:0]  a_size;
    done_c = 0; err_s = 0; busy_done = 0; seen_addr = 0; busy_bad = 0;
    a_write = 0; a_addr = '0; wd_seen = '0; a_size = '0;
    aw_left = op.aw; plan_dw = op.dw; cur_err = op.rerr;
    use_ovr = op.ovr; ovr_data = op.hrd;
    step();
    if (op.kind == 1'b0) begin
      if_en = 1'b1; pc = op.addr;
    end else begin
      mem_en = 1'b1; mem_we = op.we; mem_size = op.size;
      mem_addr = op.addr; mem_wdata = op.wdata;
    end
    for (int c = 1; c <= 24 && done_c == 0; c++) begin
      step();
      if (c == 1) begin
        if_en = 1'b0; mem_en = 1'b0;
        if (op.kind == 1'b0) tb_if_pend = 1'b1; else tb_mem_pend = 1'b1;
      end
      if (HTRANS == HTRANS_NONSEQ && !seen_addr) begin
        seen_addr = 1'b1; a_addr = HADDR; a_write = HWRITE; a_size = HSIZE;
      end
      if (in_data) wd_seen = HWDATA;
      if (done) begin
        done_c = c; err_s = err; busy_done = busy;
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
    end
    tb_if_pend = 1'b0; tb_mem_pend = 1'b0;
    chk({tag, " latency"}, done_c, ex.lat);
    chk({tag, " err"}, {31'b0, err_s}, {31'b0, ex.err});
    chk({tag, " value"}, op.kind ? rdata : instr, ex.val);
    chk({tag, " busy"}, {30'b0, busy_bad, busy_done}, 32'd0);
    if (ex.lat == 1) begin
      chk({tag, " no bus transfer"}, {31'b0, seen_addr}, 32'd0);
    end else begin
      chk({tag, " haddr"}, a_addr, op.addr);
      chk({tag, " hsize"}, {29'b0, a_size}, {29'b0, ex.hsize});
      chk({tag, " hwrite"}, {31'b0, a_write}, {31'b0, op.kind & op.we});
      if (op.kind && op.we) chk({tag, " hwdata"}, wd_seen, ex.hwdata);
    end
    step();
    chk({tag, " done width"}, {31'b0, done}, 32'd0);
  endtask

  function automatic vec_t mk(input bit kind, input logic [31:0] addr, input logic [1:0] size,
                              input logic we, input logic [31:0] wdata, input int aw, input int dw,
                              input logic rerr, input logic [31:0] hrd, input int lat, input logic e,
                              input logic [31:0] val, input logic [2:0] hs, input logic [31:0] hwd);
    vec_t v;
    v.op.kind = kind; v.op.addr = addr; v.op.size = size; v.op.we = we; v.op.wdata = wdata;
    v.op.aw = aw; v.op.dw = dw; v.op.rerr = rerr; v.op.ovr = 1'b1; v.op.hrd = hrd;
    v.ex.lat = lat; v.ex.err = e; v.ex.val = val; v.ex.hsize = hs; v.ex.hwdata = hwd;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t tbl[13];

  initial begin
    op_t         op;
    exp_t        ex;
    bit          mis;
    int          f_c, l_c, d1, d2;
    logic [31:0] i_got, r_got;
    logic        busy_bad, saw_done;

    tbl[0]  = mk(0, 32'h100, 2'd2, 0, 32'h0,        0, 0, 0, 32'h00A00093, 3, 0, 32'h00A00093, 3'd2, 32'h0);
    tbl[1]  = mk(1, 32'h203, 2'd0, 0, 32'h0,        0, 2, 0, 32'h80FF1234, 5, 0, 32'h00000080, 3'd0, 32'h0);
    tbl[2]  = mk(1, 32'h302, 2'd1, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        3, 0, 32'h00000080, 3'd1, 32'hBEEFBEEF);
    tbl[3]  = mk(0, 32'h104, 2'd2, 0, 32'h0,        0, 1, 1, 32'h12345678, 4, 1, 32'h00A00093, 3'd2, 32'h0);
    tbl[4]  = mk(1, 32'h401, 2'd2, 0, 32'h0,        0, 0, 0, 32'h0,        1, 1, 32'h00000080, 3'd2, 32'h0);
    tbl[5]  = mk(1, 32'h502, 2'd1, 0, 32'h0,        1, 0, 0, 32'hCAFE1111, 4, 0, 32'h0000CAFE, 3'd1, 32'h0);
    tbl[6]  = mk(1, 32'h600, 2'd3, 0, 32'h0,        0, 0, 0, 32'h89ABCDEF, 3, 0, 32'h89ABCDEF, 3'd2, 32'h0);
    tbl[7]  = mk(1, 32'h701, 2'd0, 1, 32'h123456A5, 0, 0, 0, 32'h0,        3, 0, 32'h89ABCDEF, 3'd0, 32'hA5A5A5A5);
    tbl[8]  = mk(1, 32'h703, 2'd1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 1, 32'h89ABCDEF, 3'd1, 32'h0);
    tbl[9]  = mk(1, 32'h800, 2'd2, 1, 32'h0BADF00D, 0, 0, 1, 32'h0,        3, 1, 32'h89ABCDEF, 3'd2, 32'h0BADF00D);
    tbl[10] = mk(1, 32'h801, 2'd0, 0, 32'h0,        1, 1, 0, 32'h00007F00, 5, 0, 32'h0000007F, 3'd0, 32'h0);
    tbl[11] = mk(0, 32'h108, 2'd2, 0, 32'h0,        2, 0, 0, 32'h00B00113, 5, 0, 32'h00B00113, 3'd2, 32'h0);
    tbl[12] = mk(1, 32'h305, 2'd1, 1, 32'h00001111, 0, 0, 0, 32'h0,        1, 1, 32'h0000007F, 3'd1, 32'h0);

    // Reset state
    step(); step();
    chk("reset htrans", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
    chk("reset haddr", HADDR, 32'h0);
    chk("reset hwrite_hsize", {28'b0, HWRITE, HSIZE}, 32'h0);
    chk("reset hwdata", HWDATA, 32'h0);
    chk("reset hburst", {29'b0, HBURST}, 32'h0);
    chk("reset instr", instr, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset busy_done_err", {29'b0, busy, done, err}, 32'h0);
    chk("reset state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].ex);
      if (tbl[i].op.kind == 1'b0) m_instr = tbl[i].ex.val;
      else m_rdata = tbl[i].ex.val;
    end

    // Simultaneous fetch and load: fetch first, load address phase at T+4
    aw_left = 0; plan_dw = 0; cur_err = 1'b0; use_ovr = 1'b0;
    f_c = 0; l_c = 0; d1 = 0; d2 = 0; i_got = '0; r_got = '0; busy_bad = 1'b0;
    step();
    if_en = 1'b1; pc = 32'h900;
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin
        if_en = 1'b0; mem_en = 1'b0; tb_if_pend = 1'b1; tb_mem_pend = 1'b1;
      end
      if (HTRANS == HTRANS_NONSEQ && HADDR == 32'h900 && f_c == 0) f_c = c;
      if (HTRANS == HTRANS_NONSEQ && HADDR == 32'h400 && l_c == 0) l_c = c;
      if (done) begin
        if (d1 == 0) begin d1 = c; i_got = instr; tb_if_pend = 1'b0; end
        else if (d2 == 0) begin d2 = c; r_got = rdata; tb_mem_pend = 1'b0; end
      end
      if (c <= 5 && !busy) busy_bad = 1'b1;
    end
    tb_if_pend = 1'b0; tb_mem_pend = 1'b0;
    m_instr = slave_word(32'h900);
    m_rdata = slave_word(32'h400);
    chk("simul fetch addr phase", f_c, 32'd1);
    chk("simul fetch done", d1, 32'd3);
    chk("simul load addr phase", l_c, 32'd4);
    chk("simul load done", d2, 32'd6);
    chk("simul instr", i_got, m_instr);
    chk("simul rdata", r_got, m_rdata);
    chk("simul busy", {31'b0, busy_bad}, 32'd0);

    // Randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      op.kind  = 1'($urandom_range(0, 1));
      op.addr  = $urandom();
      op.size  = 2'($urandom_range(0, 3));
      op.we    = 1'($urandom_range(0, 1));
      op.wdata = $urandom();
      op.aw    = $urandom_range(0, 2);
      op.dw    = $urandom_range(0, 2);
      op.rerr  = ($urandom_range(0, 7) == 0);
      op.ovr   = 1'b0;
      op.hrd   = '0;
      if (op.kind == 1'b0) begin
        op.we = 1'b0; op.size = 2'd2;
      end
      mis       = op.kind && m_mis(op.size, op.addr);
      ex.lat    = mis ? 1 : 3 + op.aw + op.dw;
      ex.err    = mis || op.rerr;
      ex.hsize  = m_hsize(op.size);
      ex.hwdata = m_lanes(op.size, op.wdata);
      if (op.kind == 1'b0) begin
        if (!op.rerr) m_instr = slave_word(op.addr);
        ex.val = m_instr;
      end else begin
        if (!mis && !op.rerr && !op.we) m_rdata = m_extract(op.size, op.addr, slave_word(op.addr));
        ex.val = m_rdata;
      end
      run_op($sformatf("rand%0d", i), op, ex);
    end

    // Reset during a data-phase wait: abandon, no done
    aw_left = 0; plan_dw = 6; cur_err = 1'b0; use_ovr = 1'b0;
    step();
    if_en = 1'b1; pc = 32'hA00;
    step();
    if_en = 1'b0; tb_if_pend = 1'b1;
    step();
    step();
    chk("pre-reset in data phase", {31'b0, in_data}, 32'd1);
    reset = 1'b1; data_active = 1'b0;
    step();
    chk("midreset htrans", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset instr", instr, 32'h0);
    reset = 1'b0; tb_if_pend = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    chk("postreset quiet", {31'b0, saw_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
